// File: rtl/hamming_enc_stream.sv
// Streaming Hamming encoder feeding a 2-entry output FIFO, with optional
// single-bit corruption per word and a saturating count of corrupted words.
module hamming_enc_stream #(
  parameter int IP_BIT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IP_BIT-1:0] in_data,
  input  logic              inj_en,
  input  logic [3:0]        inj_pos,
  output logic              in_ready,
  output logic              out_valid,
  output logic [IP_BIT+3:0] out_code,
  input  logic              out_ready,
  output logic [7:0]        inj_cnt
);

  localparam int CW = IP_BIT + 4;

  // Index into in_data of the data bit placed at codeword position p.
  function automatic int data_idx(input int p);
    int k;
    k = 0;
    for (int q = 3; q < p; q++) begin
      if ((q & (q - 1)) != 0) k++;
    end
    return IP_BIT - 1 - k;
  endfunction

  // Bits of the codeword whose position index shares a set bit with p.
  function automatic logic [CW-1:0] par_mask(input int p);
    logic [CW-1:0] m;
    m = '0;
    for (int q = 1; q <= CW; q++) begin
      if ((q & p) != 0) m = m | ({{(CW-1){1'b0}}, 1'b1} << (CW - q));
    end
    return m;
  endfunction

  logic [CW-1:0] raw;
  logic [CW-1:0] code_clean;
  logic [CW-1:0] flip;
  logic [CW-1:0] code_w;
  logic          inj_hit;

  // Vector bit gi holds codeword position CW-gi (position 1 is the MSB).
  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_pos
      localparam int P = CW - gi;
      if ((P & (P - 1)) == 0) begin : g_par
        assign raw[gi]        = 1'b0;
        assign code_clean[gi] = ^(raw & par_mask(P));
      end else begin : g_dat
        assign raw[gi]        = in_data[data_idx(P)];
        assign code_clean[gi] = raw[gi];
      end
      assign flip[gi] = inj_hit && (inj_pos == 4'(P));
    end
  endgenerate

  assign inj_hit = inj_en && (inj_pos != 4'd0) && (inj_pos <= 4'(CW));
  assign code_w  = code_clean ^ flip;

  logic [CW-1:0] mem_q [2];
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [7:0]    inj_cnt_q, inj_cnt_d;
  logic          push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_code  = mem_q[rd_ptr_q];
  assign inj_cnt   = inj_cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    inj_cnt_d = inj_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push && inj_hit && (inj_cnt_q != 8'hFF)) inj_cnt_d = inj_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      inj_cnt_q <= 8'd0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      inj_cnt_q <= inj_cnt_d;
      if (push) mem_q[wr_ptr_q] <= code_w;
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Self-checking bench for hamming_enc_stream: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_hamming_enc_stream;

  localparam int IP_BIT = 5;
  localparam int N      = IP_BIT + 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [IP_BIT-1:0] in_data = '0;
  logic              inj_en = 1'b0;
  logic [3:0]        inj_pos = 4'd0;
  logic              in_ready;
  logic              out_valid;
  logic [N-1:0]      out_code;
  logic              out_ready = 1'b0;
  logic [7:0]        inj_cnt;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] q[$];
  int           m_cnt = 0;

  hamming_enc_stream #(.IP_BIT(IP_BIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .inj_en(inj_en), .inj_pos(inj_pos), .in_ready(in_ready),
    .out_valid(out_valid), .out_code(out_code), .out_ready(out_ready),
    .inj_cnt(inj_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoding built position by position from the codeword rules.
  function automatic logic [N-1:0] ref_encode(input logic [IP_BIT-1:0] d,
                                              input logic en, input logic [3:0] pos);
    int c[16];
    int k;
    int x;
    logic [N-1:0] r;
    for (int p = 0; p < 16; p++) c[p] = 0;
    k = IP_BIT - 1;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = int'(d[k]);
        k--;
      end
    end
    for (int i = 0; i < 4; i++) begin
      x = 0;
      for (int p = 1; p <= N; p++)
        if ((((p >> i) & 1) == 1) && (p != (1 << i))) x = x ^ c[p];
      c[1 << i] = x;
    end
    if (en && pos >= 1 && int'(pos) <= N) c[pos] = c[pos] ^ 1;
    for (int p = 1; p <= N; p++) r[N-p] = c[p][0];
    return r;
  endfunction

  // One clock edge; the model follows the handshake rules with its own occupancy.
  task automatic step();
    logic push_m, pop_m;
    push_m = in_valid && (q.size() < 2);
    pop_m  = out_ready && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(ref_encode(in_data, inj_en, inj_pos));
        if (inj_en && inj_pos >= 1 && int'(inj_pos) <= N && m_cnt < 255) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_code !== '0) begin errors++; $display("FAIL reset_out_code got=%b want=0", out_code); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (inj_cnt !== 8'd0) begin errors++; $display("FAIL reset_inj_cnt got=%0d want=0", inj_cnt); end
  endtask

  task automatic test_encode();
    in_valid = 1'b1; in_data = 5'b10110; inj_en = 1'b0; inj_pos = 4'd3;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL encode_valid got=%b want=1", out_valid); end
    checks++; if (out_code !== 9'b011001100) begin errors++; $display("FAIL encode_code got=%b want=011001100", out_code); end
    checks++; if (inj_cnt !== 8'd0) begin errors++; $display("FAIL encode_inj_cnt got=%0d want=0", inj_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL encode_drain got=%b want=0", out_valid); end
    $display("encode: data=10110 code=%b", 9'b011001100);
  endtask

  task automatic test_inject();
    in_valid = 1'b1; in_data = 5'b10110; inj_en = 1'b1; inj_pos = 4'd3;
    step();
    checks++; if (out_code !== 9'b010001100) begin errors++; $display("FAIL inject_code got=%b want=010001100", out_code); end
    checks++; if (inj_cnt !== 8'd1) begin errors++; $display("FAIL inject_cnt got=%0d want=1", inj_cnt); end
    inj_pos = 4'd10; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_code !== 9'b011001100) begin errors++; $display("FAIL inject_oob_code got=%b want=011001100", out_code); end
    checks++; if (inj_cnt !== 8'd1) begin errors++; $display("FAIL inject_oob_cnt got=%0d want=1", inj_cnt); end
    step();
    out_ready = 1'b0; inj_en = 1'b0;
    $display("inject: pos3 and pos10 words handled, inj_cnt=%0d", inj_cnt);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 5'b00000;
    step();
    in_data = 5'b11111;
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
    step();
    checks++; if (out_code !== 9'b000000000) begin errors++; $display("FAIL bp_hold_code got=%b want=000000000", out_code); end
    out_ready = 1'b1;
    step();
    checks++; if (out_code !== 9'b011111111) begin errors++; $display("FAIL bp_second_code got=%b want=011111111", out_code); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got=%b want=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    out_ready = 1'b0;
    $display("backpressure: two words held then drained in order");
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1; inj_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = IP_BIT'(i);
      step();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_flags[%0d] got=%b%b want=11", i, out_valid, in_ready); end
      checks++; if (out_code !== ref_encode(IP_BIT'(i), 1'b0, 4'd0)) begin errors++; $display("FAIL stream_code[%0d] got=%b want=%b", i, out_code, ref_encode(IP_BIT'(i), 1'b0, 4'd0)); end
      $display("stream: word=%0d code=%b", i, out_code);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = IP_BIT'($urandom);
      inj_en    = 1'($urandom);
      inj_pos   = 4'($urandom_range(0, 15));
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, out_valid, q.size() != 0); end
      checks++; if (in_ready !== (q.size() != 2)) begin errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, in_ready, q.size() != 2); end
      if (q.size() != 0) begin
        checks++; if (out_code !== q[0]) begin errors++; $display("FAIL rand_code[%0d] got=%b want=%b", i, out_code, q[0]); end
      end
      checks++; if (inj_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d] got=%0d want=%0d", i, inj_cnt, m_cnt); end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    $display("random: 200 cycles, inj_cnt=%0d", inj_cnt);
  endtask

  task automatic test_saturation();
    logic [IP_BIT-1:0] d;
    in_valid = 1'b1; out_ready = 1'b1; inj_en = 1'b1; inj_pos = 4'd1;
    for (int i = 0; i < 300; i++) begin
      d = IP_BIT'($urandom);
      in_data = d;
      step();
      checks++; if (out_code !== (ref_encode(d, 1'b0, 4'd0) ^ {1'b1, {(N-1){1'b0}}})) begin errors++; $display("FAIL sat_code[%0d] got=%b", i, out_code); end
      checks++; if (inj_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, inj_cnt, m_cnt); end
    end
    in_valid = 1'b0; inj_en = 1'b0;
    step();
    checks++; if (inj_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d want=255", inj_cnt); end
    out_ready = 1'b0;
    $display("saturation: 300 corrupted words, inj_cnt=%0d", inj_cnt);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; inj_en = 1'b1; inj_pos = 4'd5;
    in_data = 5'b00011; step();
    in_data = 5'b01100; step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got=%b want=0", in_ready); end
    rst = 1'b1; out_ready = 1'b1; in_data = 5'b10101;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    checks++; if (out_code !== '0) begin errors++; $display("FAIL rstmid_code got=%b want=0", out_code); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", in_ready); end
    checks++; if (inj_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d want=0", inj_cnt); end
    in_valid = 1'b1; in_data = 5'b01001;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_code !== ref_encode(5'b01001, 1'b0, 4'd0)) begin errors++; $display("FAIL rstmid_next got=%b want=%b", out_code, ref_encode(5'b01001, 1'b0, 4'd0)); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_ghost got=%b want=0", out_valid); end
    out_ready = 1'b0;
    $display("reset_mid: buffer flushed, in-flight word discarded");
  endtask

  initial begin
    test_reset();
    test_encode();
    test_inject();
    test_backpressure();
    test_streaming();
    test_reset();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
